rle1_enc_serializer: RTL and testbench
======================================

// Module: rle1_enc_serializer
// PURPOSE
//  Upstream feeder for the rle1 encoder. Accepts parallel sample words, each with a frame-end flag.
//  Buffers them in a small FIFO.
//  Emits them one bit per beat on the encoder's 2-bit input channel {last, bit}.
//  Sits between the demuxed io_in bus and rle1_enc_wrap. Lets the pads load a whole word at once
//  instead of bit-banging the encoder.
// PARAMETERS
//  WIDTH      8  bits per input word (>=2)
//  DEPTH      2  input FIFO entries (power of 2, >=2)
//  MSB_FIRST  1  1: bit WIDTH-1 emitted first; 0: bit 0 emitted first
// PORTS
//  clk                 in   1      sole clock, rising edge
//  reset               in   1      synchronous, active-high
//  ser__input_r        in   WIDTH  sample word
//  ser__input_r_last   in   1      word is last of frame
//  ser__input_r_vld    in   1      input word valid
//  ser__input_r_rdy    out  1      block can accept a word
//  ser__output_s       out  2      [1]=last, [0]=data bit; drives rle1__input_r
//  ser__output_s_vld   out  1      output beat valid; drives rle1__input_r_vld
//  ser__output_s_rdy   in   1      encoder ready; from rle1__input_r_rdy
//  busy                out  1      FIFO non-empty or shifter loaded
// BEHAVIOUR
//  - Transfer rule: a transfer occurs on an edge where vld&&rdy. Otherwise nothing moves.
//  - Reset: on an edge with reset=1, FIFO, shifter, bit counter and flags all clear.
//    While reset is high: ser__input_r_rdy=0, ser__output_s_vld=0, ser__output_s=2'b00, busy=0.
//    Reset mid-word discards all in-flight data; no partial word is completed.
//  - FIFO (DEPTH x {last,word}):
//    ser__input_r_rdy = !reset && (count != DEPTH). The registered count is used; there is no
//    combinational path from ser__output_s_rdy.
//    When full, a push is refused even if a pop occurs on the same edge.
//    Push and pop on the same edge (not full) leave count unchanged.
//    Pointers wrap modulo DEPTH.
//  - Shifter states:
//    IDLE: no word loaded, ser__output_s_vld=0.
//    SHIFT: word loaded, ser__output_s_vld=1.
//    IDLE->SHIFT on an edge where the FIFO is non-empty. That edge pops the head into the
//    shifter and clears bit_cnt.
//    In SHIFT, each output transfer increments bit_cnt.
//    On the transfer with bit_cnt==WIDTH-1:
//      - if the FIFO is non-empty, the next word loads on the same edge (no bubble) and the
//        state stays SHIFT;
//      - otherwise the state goes to IDLE.
//  - Output: ser__output_s[0] = shifter bit at index bit_cnt (MSB_FIRST=0) or WIDTH-1-bit_cnt (MSB_FIRST=1).
//    ser__output_s[1] = word_last && (bit_cnt==WIDTH-1).
//    The output is held stable while vld && !rdy.
//  - Latency: word pushed into an empty block on edge N -> first bit valid after edge N+1.
//    Steady-state throughput is 1 bit/cycle when ser__output_s_rdy=1.
//  - bit_cnt width is $clog2(WIDTH). count width is $clog2(DEPTH)+1.
//  - busy = (count!=0) || (state==SHIFT).
// TESTING
//  1. Reset held 3 cycles while vld=1 -> in_rdy=0, out_vld=0, busy=0; FIFO empty after release.
//  2. Push 8'hA5 last=1, out_rdy=1 -> out_vld rises 2 edges after push;
//     bits 1,0,1,0,0,1,0,1; [1]=1 only on 8th beat; then out_vld=0.
//  3. Push 8'hF0, then 8'h0F last=1, out_rdy=1 -> 16 consecutive beats with no gap;
//     last flag only on beat 16.
//  4. out_rdy=0, push 3 words -> word 1 enters shifter, FIFO fills 2, in_rdy=0;
//     a 4th vld is not accepted; output beat held unchanged.
//  5. Toggle out_rdy 1-0-1-0 during a word -> each bit emitted exactly once, in order.
//  6. Reset after 3 bits of 8'hC3 -> out_vld=0 next cycle; new word 8'h81 emits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/rle1_enc_serializer.sv
// Word-to-bit serializer feeding the rle1 encoder: a small {last,word} FIFO in front of a shifter
// that emits one {last,bit} beat per output handshake.
module rle1_enc_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ser__input_r,
    input  logic             ser__input_r_last,
    input  logic             ser__input_r_vld,
    output logic             ser__input_r_rdy,
    output logic [1:0]       ser__output_s,
    output logic             ser__output_s_vld,
    input  logic             ser__output_s_rdy,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             word_last_q, word_last_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

    logic             push, pop, out_fire, fifo_nempty;
    logic [BW-1:0]    bit_idx;

    // Ready comes only from the registered count, so no rdy->rdy combinational path exists.
    assign ser__input_r_rdy  = !reset && (count_q != FULL_CNT);
    assign ser__output_s_vld = !reset && (state_q == S_SHIFT);
    assign busy              = !reset && ((count_q != '0) || (state_q == S_SHIFT));

    assign fifo_nempty = (count_q != '0);
    assign push        = ser__input_r_vld && ser__input_r_rdy;
    assign out_fire    = ser__output_s_vld && ser__output_s_rdy;
    assign bit_idx     = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt_q) : bit_cnt_q;

    always_comb begin
        ser__output_s = 2'b00;
        if (ser__output_s_vld) begin
            ser__output_s = {word_last_q && (bit_cnt_q == LAST_BIT), shreg_q[bit_idx]};
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        word_last_d = word_last_q;
        bit_cnt_d   = bit_cnt_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (out_fire) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Back-to-back words reload on the final beat so no bubble appears.
                        if (fifo_nempty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            {word_last_d, shreg_d} = mem_q[rd_ptr_q];
            bit_cnt_d              = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            word_last_q <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            word_last_q <= word_last_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ser__input_r_last, ser__input_r};
        end
    end

endmodule

// File: tb/tb_rle1_enc_serializer.sv
// Directed bench for rle1_enc_serializer: hand-computed bit streams, stalls, back-to-back words and reset.
module tb_rle1_enc_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_vld;
    logic       in_rdy;
    logic [1:0] out_s;
    logic       out_vld;
    logic       out_rdy;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    rle1_enc_serializer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .ser__input_r      (in_data),
        .ser__input_r_last (in_last),
        .ser__input_r_vld  (in_vld),
        .ser__input_r_rdy  (in_rdy),
        .ser__output_s     (out_s),
        .ser__output_s_vld (out_vld),
        .ser__output_s_rdy (out_rdy),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] w, input logic l);
        int t = 0;
        in_data = w;
        in_last = l;
        in_vld  = 1'b1;
        while (!in_rdy && t < 20) begin
            step();
            t++;
        end
        if (!in_rdy) check("push_timeout", 32'd0, 32'd1);
        step();
        in_vld = 1'b0;
    endtask

    task automatic wait_out_vld(input string tag);
        int t = 0;
        while (!out_vld && t < 20) begin
            step();
            t++;
        end
        if (!out_vld) check(tag, 32'd0, 32'd1);
    endtask

    task automatic collect_word(input string tag, input logic [7:0] w, input logic l);
        for (int i = 0; i < 8; i++) begin
            int t = 0;
            while (!(out_vld && out_rdy) && t < 20) begin
                step();
                t++;
            end
            if (!(out_vld && out_rdy)) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                return;
            end
            check({tag, "_bit"}, 32'(out_s[0]), 32'(w[7-i]));
            check({tag, "_last"}, 32'(out_s[1]), 32'(l && (i == 7)));
            step();
        end
    endtask

    initial begin
        logic [15:0] exp_bits;
        logic [7:0]  w;
        int          idx;
        int          cyc;

        reset   = 1'b1;
        in_data = 8'h3C;
        in_last = 1'b0;
        in_vld  = 1'b1;
        out_rdy = 1'b1;

        // 1: reset held with vld high
        repeat (3) begin
            @(negedge clk);
            check("rst_in_rdy", 32'(in_rdy), 32'd0);
            check("rst_out_vld", 32'(out_vld), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_out_s", 32'(out_s), 32'd0);
        end
        in_vld = 1'b0;
        reset  = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
        check("post_rst_out_vld", 32'(out_vld), 32'd0);

        // 2: single word, latency then 1,0,1,0,0,1,0,1
        push_word(8'hA5, 1'b1);
        check("lat_vld_low", 32'(out_vld), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        step();
        check("lat_vld_high", 32'(out_vld), 32'd1);
        collect_word("a5", 8'hA5, 1'b1);
        check("a5_done_vld", 32'(out_vld), 32'd0);
        check("a5_done_busy", 32'(busy), 32'd0);

        // 3: two words back to back with no gap
        push_word(8'hF0, 1'b0);
        push_word(8'h0F, 1'b1);
        wait_out_vld("b2b_timeout");
        exp_bits = 16'hF00F;
        for (int i = 0; i < 16; i++) begin
            check("b2b_vld", 32'(out_vld), 32'd1);
            check("b2b_bit", 32'(out_s[0]), 32'(exp_bits[15-i]));
            check("b2b_last", 32'(out_s[1]), 32'(i == 15));
            step();
        end
        check("b2b_done_vld", 32'(out_vld), 32'd0);

        // 4: stalled output, FIFO fills, fourth word refused
        out_rdy = 1'b0;
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b1);
        check("full_in_rdy", 32'(in_rdy), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        in_data = 8'h44;
        in_last = 1'b0;
        in_vld  = 1'b1;
        repeat (3) begin
            check("full_in_rdy_hold", 32'(in_rdy), 32'd0);
            check("stall_vld", 32'(out_vld), 32'd1);
            check("stall_out_s", 32'(out_s), 32'd0);
            step();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        collect_word("w11", 8'h11, 1'b0);
        collect_word("w22", 8'h22, 1'b0);
        collect_word("w33", 8'h33, 1'b1);
        check("w33_done_vld", 32'(out_vld), 32'd0);
        check("w33_done_busy", 32'(busy), 32'd0);

        // 5: toggling out_rdy during a word
        out_rdy = 1'b0;
        push_word(8'h5A, 1'b1);
        wait_out_vld("tog_timeout");
        w   = 8'h5A;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            out_rdy = (cyc % 2 == 0);
            check("tog_vld", 32'(out_vld), 32'd1);
            check("tog_bit", 32'(out_s[0]), 32'(w[7-idx]));
            check("tog_last", 32'(out_s[1]), 32'(w == 8'h5A && idx == 7));
            if (out_rdy) idx++;
            step();
            cyc++;
        end
        check("tog_beats", 32'(idx), 32'd8);
        out_rdy = 1'b1;
        check("tog_done_vld", 32'(out_vld), 32'd0);

        // 6: reset mid-word discards it
        push_word(8'hC3, 1'b1);
        wait_out_vld("mid_timeout");
        w = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            check("mid_bit", 32'(out_s[0]), 32'(w[7-i]));
            step();
        end
        reset = 1'b1;
        step();
        check("mid_rst_vld", 32'(out_vld), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        reset = 1'b0;
        step();
        check("mid_post_vld", 32'(out_vld), 32'd0);
        check("mid_post_busy", 32'(busy), 32'd0);
        push_word(8'h81, 1'b1);
        collect_word("w81", 8'h81, 1'b1);
        check("w81_done_vld", 32'(out_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
